voice_mixer: RTL and testbench
==============================

VOICE_MIXER -- requirements
Module: voice_mixer

Interface
REQ-001 Parameter N_VOICES, default 16: number of oscillator voices summed (2..64).
REQ-002 Parameter IN_WIDTH, default `SAMPLE_WIDTH+`FIXED_POINT: width of each signed fixed-point voice input.
REQ-003 Parameter OUT_WIDTH, default `SAMPLE_WIDTH: width of the signed integer output sample.
REQ-004 clk  input  1  system clock; the block has one clock.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 sample_tick  input  1  one-cycle pulse at the audio sample rate.
REQ-007 voices  input  N_VOICES x IN_WIDTH signed  oscillator outputs, one per voice.
REQ-008 voice_enable  input  N_VOICES  per-voice enable (the wavegen enable bit per voice).
REQ-009 master_volume  input  9 unsigned  gain, Q1.8; 256 is unity gain; values above 256 amplify.
REQ-010 sample_out  output  OUT_WIDTH signed  mixed, scaled, saturated sample.
REQ-011 sample_valid  output  1  sample_out holds an unconsumed sample.
REQ-012 sample_ready  input  1  consumer (DAC/I2S) accepts the sample when valid and ready are both high.
REQ-013 busy  output  1  high while the FSM is not IDLE.
REQ-014 overrun  output  1  sticky flag; a tick arrived while busy, or an unconsumed sample was overwritten.

Function
REQ-015 FSM states, in order: IDLE, ACCUM, SCALE, EMIT.
- IDLE -> ACCUM on sample_tick.
- ACCUM -> SCALE after N_VOICES cycles.
- SCALE -> EMIT after 1 cycle.
- EMIT -> IDLE after 1 cycle.
REQ-016 On the edge where sample_tick is sampled in IDLE: snapshot all voices and voice_enable, and snapshot master_volume; clear the accumulator.
REQ-017 ACCUM adds one snapshot voice per cycle, index 0 first, to a signed accumulator of width IN_WIDTH+$clog2(N_VOICES)+1; a disabled voice adds zero.
REQ-018 The voice index counter wraps to 0 when leaving ACCUM; no overflow is possible in the accumulator.
REQ-019 SCALE multiplies the accumulator by the snapshot master_volume and arithmetic-shifts right by 8+`FIXED_POINT (truncation toward negative infinity).
REQ-020 EMIT saturates the SCALE result to OUT_WIDTH signed:
- values > 2^(OUT_WIDTH-1)-1 clamp to that maximum;
- values < -2^(OUT_WIDTH-1) clamp to that minimum.
EMIT then loads sample_out and sets sample_valid.
REQ-021 Latency: with the tick sampled at edge k, sample_valid is high after edge k+N_VOICES+2.
REQ-022 sample_valid falls on the edge after a valid&&ready handshake; sample_out is held stable while sample_valid is high.
REQ-023 If EMIT occurs while sample_valid is still high, the new sample overwrites the old one, sample_valid stays high, and overrun is set.
REQ-024 If EMIT and a handshake occur on the same edge, the new sample is loaded, sample_valid stays high, and overrun is not set.
REQ-025 A sample_tick while busy is ignored (no restart) and sets overrun.
REQ-026 Input changes after the snapshot edge do not affect the sample in progress.

Reset
REQ-027 On rst: FSM=IDLE, accumulator=0, index=0, sample_out=0, sample_valid=0, busy=0, overrun=0.
REQ-028 Reset mid-ACCUM/SCALE aborts the sample; no sample_valid follows it.
REQ-029 rst has priority over sample_tick in the same cycle.

Structure
REQ-030 The FSM state enum mixer_state_t and the constant MIXER_VOLUME_UNITY=256 live in a shared package mixer_pkg.
REQ-031 `SAMPLE_WIDTH and `FIXED_POINT come from constants.svh; they are not redefined.
REQ-032 Saturation is a parameterised combinational sub-module, saturate (IN_W, OUT_W).

Verification
REQ-033 Each scenario below is driven by a directed bench.
- N_VOICES=4, voices {1000,2000,-500,0} in fixed point, all enabled, volume 256, tick -> sample_out=2500, valid exactly 6 cycles after tick.
- Same voices, voice_enable=4'b0101, volume 128 -> sample_out=250.
- All 4 voices at max positive, volume 256 -> sample_out=2^(OUT_WIDTH-1)-1; all at max negative -> sample_out=-2^(OUT_WIDTH-1).
- Hold sample_ready=0 across two ticks -> second sample replaces first, overrun=1; ready=1 one cycle -> valid drops next edge.
- Second tick 2 cycles after first -> ignored, overrun=1, only one sample emitted.
- rst asserted 2 cycles into ACCUM -> all outputs 0; no valid until the next tick plus 6 cycles.

Source files
------------

// File: rtl/mixer_pkg.sv
// rtl/mixer_pkg.sv - shared types and constants for the voice mixer
package mixer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SCALE = 2'd2,
        EMIT  = 2'd3
    } mixer_state_t;

    localparam int MIXER_VOLUME_UNITY = 256;

    // Accumulator width that cannot overflow when summing n_voices inputs of in_w bits
    function automatic int mixer_acc_width(input int in_w, input int n_voices);
        return in_w + $clog2(n_voices) + 1;
    endfunction

endpackage

// File: rtl/constants.svh
// rtl/constants.svh - shared audio sample width and fixed-point constants
`ifndef CONSTANTS_SVH
`define CONSTANTS_SVH

`define SAMPLE_WIDTH 16
`define FIXED_POINT  8

`endif

// File: rtl/saturate.sv
// rtl/saturate.sv - signed saturation from IN_W bits down to OUT_W bits
module saturate #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

    localparam longint MAX_L = (longint'(1) <<< (OUT_W - 1)) - 1;
    localparam logic signed [IN_W-1:0] MAX_V = IN_W'(MAX_L);
    localparam logic signed [IN_W-1:0] MIN_V = IN_W'(-MAX_L - 1);

    // Clamp out-of-range values, otherwise pass the low bits through unchanged
    always_comb begin
        dout = din[OUT_W-1:0];
        if (din > MAX_V) begin
            dout = MAX_V[OUT_W-1:0];
        end else if (din < MIN_V) begin
            dout = MIN_V[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/voice_mixer.sv
// rtl/voice_mixer.sv - sums enabled voices, applies master volume, saturates and hands off one sample per tick
`include "constants.svh"

module voice_mixer
    import mixer_pkg::*;
#(
    parameter int N_VOICES  = 16,
    parameter int IN_WIDTH  = `SAMPLE_WIDTH + `FIXED_POINT,
    parameter int OUT_WIDTH = `SAMPLE_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sample_tick,
    input  logic signed [IN_WIDTH-1:0]  voices [N_VOICES],
    input  logic [N_VOICES-1:0]         voice_enable,
    input  logic [8:0]                  master_volume,
    output logic signed [OUT_WIDTH-1:0] sample_out,
    output logic                        sample_valid,
    input  logic                        sample_ready,
    output logic                        busy,
    output logic                        overrun
);

    localparam int IDX_W  = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
    localparam int ACC_W  = mixer_acc_width(IN_WIDTH, N_VOICES);
    localparam int PROD_W = ACC_W + 10;
    localparam int SHIFT  = 8 + `FIXED_POINT;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VOICES - 1);

    mixer_state_t state, next_state;

    logic signed [IN_WIDTH-1:0]  voice_snap [N_VOICES];
    logic [N_VOICES-1:0]         enable_snap;
    logic [8:0]                  volume_snap;
    logic signed [ACC_W-1:0]     acc;
    logic signed [ACC_W-1:0]     addend;
    logic [IDX_W-1:0]            idx;
    logic signed [PROD_W-1:0]    product;
    logic signed [PROD_W-1:0]    scaled;
    logic signed [OUT_WIDTH-1:0] sat_out;

    logic start;
    assign start = (state == IDLE) && sample_tick;
    assign busy  = (state != IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: one pass of ACCUM per voice, then a cycle each for SCALE and EMIT
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (sample_tick) next_state = ACCUM;
            ACCUM:   if (idx == LAST_IDX) next_state = SCALE;
            SCALE:   next_state = EMIT;
            EMIT:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Capture inputs at the start of a sample so later input changes cannot disturb it
    always_ff @(posedge clk) begin
        if (start && !rst) begin
            voice_snap  <= voices;
            enable_snap <= voice_enable;
            volume_snap <= master_volume;
        end
    end

    // Disabled voices contribute zero; sign-extend enabled ones to the accumulator width
    always_comb begin
        addend = '0;
        if (enable_snap[idx]) begin
            addend = ACC_W'(voice_snap[idx]);
        end
    end

    // Volume is unsigned, so a zero sign bit is prepended before the signed multiply
    assign product = PROD_W'(acc) * PROD_W'($signed({1'b0, volume_snap}));

    // Accumulate voices and scale the sum
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            idx    <= '0;
            scaled <= '0;
        end else begin
            if (start) begin
                acc <= '0;
                idx <= '0;
            end
            if (state == ACCUM) begin
                acc <= acc + addend;
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
            if (state == SCALE) begin
                scaled <= product >>> SHIFT;
            end
        end
    end

    saturate #(
        .IN_W  (PROD_W),
        .OUT_W (OUT_WIDTH)
    ) u_saturate (
        .din  (scaled),
        .dout (sat_out)
    );

    // Output handoff: a new sample wins over a pending one; overrun is sticky until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_out   <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (state == EMIT) begin
                sample_out   <= sat_out;
                sample_valid <= 1'b1;
                if (sample_valid && !sample_ready) begin
                    overrun <= 1'b1;
                end
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
            if (sample_tick && busy) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_voice_mixer.sv
// tb/tb_voice_mixer.sv - self-checking bench for voice_mixer
module tb_voice_mixer;

    localparam int NV = 4;
    localparam int IW = 24;
    localparam int OW = 16;
    localparam int FP = 256;
    localparam int VMAX = 8388607;
    localparam int VMIN = -8388608;

    typedef struct {
        int         v [NV];
        logic [3:0] en;
        int         vol;
        int         exp;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 sample_tick;
    logic signed [IW-1:0] voices [NV];
    logic [NV-1:0]        voice_enable;
    logic [8:0]           master_volume;
    logic signed [OW-1:0] sample_out;
    logic                 sample_valid;
    logic                 sample_ready;
    logic                 busy;
    logic                 overrun;

    int checks = 0;
    int failures = 0;

    voice_mixer #(.N_VOICES(NV), .IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .clk           (clk),
        .rst           (rst),
        .sample_tick   (sample_tick),
        .voices        (voices),
        .voice_enable  (voice_enable),
        .master_volume (master_volume),
        .sample_out    (sample_out),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .busy          (busy),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    function automatic int model(input int v [NV], input logic [3:0] en, input int vol);
        longint s = 0;
        for (int i = 0; i < NV; i++) if (en[i]) s += v[i];
        s = (s * vol) >>> 16;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return int'(s);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t t);
        for (int i = 0; i < NV; i++) voices[i] = IW'(t.v[i]);
        voice_enable  = t.en;
        master_volume = 9'(t.vol);
    endtask

    task automatic scramble();
        for (int i = 0; i < NV; i++) voices[i] = IW'($urandom);
        voice_enable  = 4'($urandom);
        master_volume = 9'($urandom);
    endtask

    // Tick, scramble inputs after the snapshot edge, wait for valid
    task automatic run_sample(input vec_t t, output int out_val, output int lat);
        apply(t);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        scramble();
        lat = 0;
        while (!sample_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        out_val = int'(sample_out);
    endtask

    task automatic consume(input string name);
        sample_ready = 1'b1;
        @(negedge clk);
        sample_ready = 1'b0;
        check({name, "_valid_drop"}, int'(sample_valid), 0);
    endtask

    vec_t tbl [$];
    vec_t t, a, b;
    int out_val, lat, seen;

    initial begin
        rst = 1'b1;
        sample_tick = 1'b0;
        sample_ready = 1'b0;
        t.v = '{0, 0, 0, 0}; t.en = '0; t.vol = 0; t.exp = 0;
        apply(t);
        repeat (3) @(negedge clk);
        check("reset_out", int'(sample_out), 0);
        check("reset_valid", int'(sample_valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_overrun", int'(overrun), 0);
        rst = 1'b0;
        @(negedge clk);

        t.v = '{1000*FP, 2000*FP, -500*FP, 0}; t.en = 4'b1111; t.vol = 256; t.exp = 2500;  tbl.push_back(t);
        t.en = 4'b0101; t.vol = 128; t.exp = 250;                                         tbl.push_back(t);
        t.v = '{VMAX, VMAX, VMAX, VMAX}; t.en = 4'b1111; t.vol = 256; t.exp = 32767;      tbl.push_back(t);
        t.v = '{VMIN, VMIN, VMIN, VMIN}; t.exp = -32768;                                  tbl.push_back(t);
        t.v = '{1000*FP, 2000*FP, -500*FP, 0}; t.en = 4'b0000; t.vol = 511; t.exp = 0;    tbl.push_back(t);
        t.v = '{-3*FP, 1, 0, 0}; t.en = 4'b0011; t.vol = 256; t.exp = -3;                 tbl.push_back(t);
        t.v = '{-1, 0, 0, 0}; t.en = 4'b0001; t.vol = 1; t.exp = -1;                      tbl.push_back(t);
        t.v = '{100*FP, 0, 0, 0}; t.en = 4'b0001; t.vol = 511; t.exp = 199;               tbl.push_back(t);

        foreach (tbl[i]) begin
            run_sample(tbl[i], out_val, lat);
            check($sformatf("vec%0d_out", i), out_val, tbl[i].exp);
            check($sformatf("vec%0d_latency", i), lat, 6);
            consume($sformatf("vec%0d", i));
        end

        // Unconsumed sample overwritten by the next one
        a = tbl[0];
        b = tbl[1];
        run_sample(a, out_val, lat);
        check("ovr_first_out", out_val, 2500);
        check("ovr_flag_clear", int'(overrun), 0);
        apply(b);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (5) @(negedge clk);
        check("ovr_held_out", int'(sample_out), 2500);
        @(negedge clk);
        check("ovr_second_out", int'(sample_out), 250);
        check("ovr_valid", int'(sample_valid), 1);
        check("ovr_flag", int'(overrun), 1);
        consume("ovr");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Second tick two cycles into a sample is ignored
        a = tbl[0];
        apply(a);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        check("dbl_overrun", int'(overrun), 1);
        lat = 2;
        while (!sample_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("dbl_latency", lat, 6);
        check("dbl_out", int'(sample_out), 2500);
        consume("dbl");
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (sample_valid) seen++;
        end
        check("dbl_single_emit", seen, 0);

        // Reset two cycles into ACCUM aborts the sample
        apply(tbl[1]);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_out", int'(sample_out), 0);
        check("rstmid_valid", int'(sample_valid), 0);
        check("rstmid_busy", int'(busy), 0);
        check("rstmid_overrun", int'(overrun), 0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (sample_valid) seen++;
        end
        check("rstmid_no_valid", seen, 0);
        run_sample(tbl[1], out_val, lat);
        check("rstmid_next_out", out_val, 250);
        check("rstmid_next_latency", lat, 6);
        consume("rstmid");

        // Randomized samples against the arithmetic model
        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < NV; i++) t.v[i] = int'($urandom_range(0, 32'h00FF_FFFF)) + VMIN;
            t.en  = 4'($urandom);
            t.vol = int'($urandom_range(0, 511));
            t.exp = model(t.v, t.en, t.vol);
            run_sample(t, out_val, lat);
            check($sformatf("rnd%0d_out", r), out_val, t.exp);
            check($sformatf("rnd%0d_latency", r), lat, 6);
            consume($sformatf("rnd%0d", r));
        end
        check("final_overrun", int'(overrun), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
